// File: rtl/hazard_unit_if.sv
// Hazard unit signal bundle: ID/EX hazard inputs, pipeline control outputs
// and the stall/flush performance counters.
interface hazard_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs2;
    logic [4:0]       idex_rd;
    logic             idex_memread;
    logic             branch_taken;
    logic             mem_busy;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             freeze;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, idex_rd, idex_memread, branch_taken, mem_busy,
        input  pc_write, ifid_write, ifid_flush, idex_flush, freeze, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, idex_rd, idex_memread, branch_taken, mem_busy,
        output pc_write, ifid_write, ifid_flush, idex_flush, freeze, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stalls, taken-branch flushes, memory freeze
// with a deferred branch, plus saturating stall/flush event counters.
module hazard_unit #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input logic          clk,
    input logic          reset,
    hazard_unit_if.slave hz
);
    typedef enum logic [1:0] {StRun, StFlush, StFreeze} state_e;

    localparam logic [2:0]       FlushInit = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    state_e           r_state, w_state_d;
    logic             r_br_pending, w_br_pending_d;
    logic [2:0]       r_flush_left, w_flush_left_d;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    logic w_lu, w_branch, w_flush_inc;
    logic w_pc_write, w_ifid_write, w_ifid_flush, w_idex_flush, w_freeze;

    assign w_lu = hz.idex_memread && (hz.idex_rd != 5'd0) &&
                  ((hz.idex_rd == hz.id_rs1) || (hz.id_uses_rs2 && (hz.idex_rd == hz.id_rs2)));

    // A branch deferred by a freeze is replayed on the first unfrozen cycle.
    assign w_branch = hz.branch_taken || (r_br_pending && (r_state != StFlush));

    always_comb begin
        w_pc_write      = 1'b1;
        w_ifid_write    = 1'b1;
        w_ifid_flush    = 1'b0;
        w_idex_flush    = 1'b0;
        w_freeze        = 1'b0;
        w_flush_inc     = 1'b0;
        w_state_d       = r_state;
        w_br_pending_d  = r_br_pending;
        w_flush_left_d  = r_flush_left;

        if (reset) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (hz.mem_busy) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_freeze     = 1'b1;
            w_state_d    = StFreeze;
            if (hz.branch_taken) begin
                w_br_pending_d = 1'b1;
            end
        end else if (w_branch) begin
            w_ifid_flush   = 1'b1;
            w_idex_flush   = 1'b1;
            w_flush_inc    = 1'b1;
            w_flush_left_d = FlushInit;
            w_br_pending_d = 1'b0;
            w_state_d      = (FLUSH_CYCLES > 1) ? StFlush : StRun;
        end else if (r_state == StFlush) begin
            w_ifid_flush   = 1'b1;
            w_idex_flush   = 1'b1;
            w_flush_left_d = (r_flush_left != 3'd0) ? r_flush_left - 3'd1 : 3'd0;
            w_state_d      = (r_flush_left <= 3'd1) ? StRun : StFlush;
        end else begin
            // Leaving a freeze resumes any flush sequence it interrupted.
            if (r_state == StFreeze) begin
                w_state_d = (r_flush_left != 3'd0) ? StFlush : StRun;
            end
            if (w_lu) begin
                w_pc_write   = 1'b0;
                w_ifid_write = 1'b0;
                w_idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StRun;
            r_br_pending <= 1'b0;
            r_flush_left <= 3'd0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_state      <= w_state_d;
            r_br_pending <= w_br_pending_d;
            r_flush_left <= w_flush_left_d;
            if (!w_pc_write && (r_stall_cnt != CntMax)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_inc && (r_flush_cnt != CntMax)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign hz.pc_write   = w_pc_write;
    assign hz.ifid_write = w_ifid_write;
    assign hz.ifid_flush = w_ifid_flush;
    assign hz.idex_flush = w_idex_flush;
    assign hz.freeze     = w_freeze;
    assign hz.stall_cnt  = r_stall_cnt;
    assign hz.flush_cnt  = r_flush_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench: directed cycles push expected outputs/counters; a negedge
// monitor pops and compares against one of two differently-parameterised DUTs.
module tb_hazard_unit;
    // {pc_write, ifid_write, ifid_flush, idex_flush, freeze}
    localparam logic [4:0] O_NORM = 5'b11000;
    localparam logic [4:0] O_RST  = 5'b00110;
    localparam logic [4:0] O_LU   = 5'b00010;
    localparam logic [4:0] O_BR   = 5'b11110;
    localparam logic [4:0] O_FRZ  = 5'b00001;

    typedef struct {
        bit          sel_a;
        logic [4:0]  outs;
        logic [31:0] stall;
        logic [31:0] flush;
        string       name;
    } exp_t;

    logic clk;
    logic rst_a, rst_b;
    int   n_checks;
    int   n_errors;
    exp_t q[$];

    hazard_unit_if #(.CNT_W(32)) bus_a ();
    hazard_unit_if #(.CNT_W(4))  bus_b ();

    hazard_unit #(.FLUSH_CYCLES(3), .CNT_W(32)) dut_a (.clk(clk), .reset(rst_a), .hz(bus_a));
    hazard_unit #(.FLUSH_CYCLES(4), .CNT_W(4))  dut_b (.clk(clk), .reset(rst_b), .hz(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input bit sel_a, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic uses, input logic [4:0] rd, input logic mr,
                          input logic br, input logic busy);
        if (sel_a) begin
            bus_a.id_rs1 = rs1; bus_a.id_rs2 = rs2; bus_a.id_uses_rs2 = uses;
            bus_a.idex_rd = rd; bus_a.idex_memread = mr;
            bus_a.branch_taken = br; bus_a.mem_busy = busy;
        end else begin
            bus_b.id_rs1 = rs1; bus_b.id_rs2 = rs2; bus_b.id_uses_rs2 = uses;
            bus_b.idex_rd = rd; bus_b.idex_memread = mr;
            bus_b.branch_taken = br; bus_b.mem_busy = busy;
        end
    endtask

    task automatic idle(input bit sel_a);
        set_in(sel_a, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue expectation for the current cycle, then advance to just after the next edge.
    task automatic step(input bit sel_a, input logic [4:0] outs, input int unsigned es,
                        input int unsigned ef, input string name);
        exp_t e;
        e.sel_a = sel_a; e.outs = outs; e.stall = es; e.flush = ef; e.name = name;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [4:0]  a_outs;
        logic [31:0] a_stall, a_flush;
        if (q.size() != 0) begin
            e = q.pop_front();
            if (e.sel_a) begin
                a_outs  = {bus_a.pc_write, bus_a.ifid_write, bus_a.ifid_flush,
                           bus_a.idex_flush, bus_a.freeze};
                a_stall = bus_a.stall_cnt;
                a_flush = bus_a.flush_cnt;
            end else begin
                a_outs  = {bus_b.pc_write, bus_b.ifid_write, bus_b.ifid_flush,
                           bus_b.idex_flush, bus_b.freeze};
                a_stall = 32'(bus_b.stall_cnt);
                a_flush = 32'(bus_b.flush_cnt);
            end
            n_checks++;
            if (a_outs !== e.outs) begin
                n_errors++;
                $display("FAIL %s outs: got %b expected %b", e.name, a_outs, e.outs);
            end
            n_checks++;
            if (a_stall !== e.stall) begin
                n_errors++;
                $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, a_stall, e.stall);
            end
            n_checks++;
            if (a_flush !== e.flush) begin
                n_errors++;
                $display("FAIL %s flush_cnt: got %0d expected %0d", e.name, a_flush, e.flush);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        idle(1'b1);
        idle(1'b0);
        @(posedge clk);
        #1;

        // DUT A: FLUSH_CYCLES=3
        step(1'b1, O_RST, 0, 0, "a_reset");
        rst_a = 1'b0;
        step(1'b1, O_NORM, 0, 0, "a_normal");
        set_in(1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        step(1'b1, O_LU, 0, 0, "a_lu_rs1");
        idle(1'b1);
        step(1'b1, O_NORM, 1, 0, "a_lu_release");
        set_in(1'b1, 5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        step(1'b1, O_LU, 1, 0, "a_lu_rs2_used");
        set_in(1'b1, 5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        step(1'b1, O_NORM, 2, 0, "a_rs2_unused");
        set_in(1'b1, 5'd0, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, O_NORM, 2, 0, "a_rd_zero");
        set_in(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, O_BR, 2, 0, "a_branch");
        idle(1'b1);
        step(1'b1, O_BR, 2, 1, "a_flush2");
        step(1'b1, O_BR, 2, 1, "a_flush3");
        step(1'b1, O_NORM, 2, 1, "a_after_flush");

        set_in(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, O_FRZ, 2, 1, "a_frz1");
        set_in(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, O_FRZ, 3, 1, "a_frz2_br");
        set_in(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, O_FRZ, 4, 1, "a_frz3");
        step(1'b1, O_FRZ, 5, 1, "a_frz4");
        idle(1'b1);
        step(1'b1, O_BR, 6, 1, "a_frz_exit_br");
        step(1'b1, O_BR, 6, 2, "a_frz_flush2");
        step(1'b1, O_BR, 6, 2, "a_frz_flush3");
        step(1'b1, O_NORM, 6, 2, "a_frz_done");

        set_in(1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        step(1'b1, O_BR, 6, 2, "a_lu_and_br");
        idle(1'b1);
        step(1'b1, O_BR, 6, 3, "a_sim_flush2");
        step(1'b1, O_BR, 6, 3, "a_sim_flush3");
        step(1'b1, O_NORM, 6, 3, "a_sim_done");

        // DUT B: FLUSH_CYCLES=4, CNT_W=4
        step(1'b0, O_RST, 0, 0, "b_reset");
        rst_b = 1'b0;
        set_in(1'b0, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, O_BR, 0, 0, "b_branch");
        idle(1'b0);
        rst_b = 1'b1;
        step(1'b0, O_RST, 0, 1, "b_reset_midflush");
        rst_b = 1'b0;
        step(1'b0, O_NORM, 0, 0, "b_after_reset");
        step(1'b0, O_NORM, 0, 0, "b_no_more_flush");

        set_in(1'b0, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            step(1'b0, O_FRZ, (i < 15) ? i : 15, 0, "b_sat_busy");
        end
        idle(1'b0);
        step(1'b0, O_NORM, 15, 0, "b_sat_exit");
        set_in(1'b0, 5'd9, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        step(1'b0, O_LU, 15, 0, "b_sat_lu");
        idle(1'b0);
        step(1'b0, O_NORM, 15, 0, "b_sat_hold");

        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The module SHALL have parameter FLUSH_CYCLES, default 1: number of cycles ifid_flush/idex_flush stay asserted per taken branch; legal range 1..7.
REQ-002 The module SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 id_rs1  input  5  rs1 field of the instruction in ID.
REQ-006 id_rs2  input  5  rs2 field of the instruction in ID.
REQ-007 id_uses_rs2  input  1  the ID instruction reads rs2 (R-type, store, branch).
REQ-008 idex_rd  input  5  rd held in the ID/EX pipeline register.
REQ-009 idex_memread  input  1  Memread held in the ID/EX pipeline register.
REQ-010 branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-011 mem_busy  input  1  data memory not ready; the pipeline must freeze.
REQ-012 pc_write  output  1  PC update enable.
REQ-013 ifid_write  output  1  IF/ID register load enable.
REQ-014 ifid_flush  output  1  clear IF/ID to a NOP.
REQ-015 idex_flush  output  1  drives the flush input of the ID/EX register (bubble insert).
REQ-016 freeze  output  1  hold enable for the ID/EX and later pipeline registers.
REQ-017 stall_cnt  output  CNT_W  count of cycles with pc_write=0, excluding reset cycles.
REQ-018 flush_cnt  output  CNT_W  count of taken-branch flush events.

Function
REQ-019 The FSM SHALL have states RUN, FLUSH and FREEZE, plus a 1-bit register br_pending and a 3-bit register flush_left.
REQ-020 Outputs SHALL be combinational from the current state and inputs; state, br_pending, flush_left and the counters SHALL be registered.
REQ-021 Load-use hazard (lu) SHALL be: idex_memread=1, idex_rd!=0, and (idex_rd==id_rs1, or id_uses_rs2=1 with idex_rd==id_rs2).
REQ-022 Priority SHALL be: reset > mem_busy > taken branch (branch_taken, or br_pending in RUN) > FLUSH state > lu > normal.
REQ-023 mem_busy=1 in any state SHALL drive pc_write=0, ifid_write=0, freeze=1, ifid_flush=0 and idex_flush=0, and the next state SHALL be FREEZE.
REQ-024 mem_busy=1 SHALL hold flush_left unchanged.
REQ-025 branch_taken=1 together with mem_busy=1 SHALL set br_pending=1.
REQ-026 FREEZE SHALL exit when mem_busy=0, to FLUSH if flush_left>0, otherwise to RUN; if br_pending=1 the taken branch SHALL be applied in that same cycle and br_pending SHALL clear.
REQ-027 A taken branch SHALL drive ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1 and freeze=0, SHALL increment flush_cnt by 1, and SHALL set flush_left=FLUSH_CYCLES-1.
REQ-028 After a taken branch the next state SHALL be FLUSH when FLUSH_CYCLES>1, otherwise RUN.
REQ-029 FLUSH SHALL drive the same outputs as a taken branch without incrementing flush_cnt, SHALL decrement flush_left, and SHALL return to RUN when flush_left reaches 0.
REQ-030 A new branch_taken in FLUSH SHALL restart flush_left at FLUSH_CYCLES-1 and SHALL increment flush_cnt.
REQ-031 lu in RUN with no branch SHALL drive pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0 and freeze=0 for exactly that cycle, with the state remaining RUN.
REQ-032 The lu bubble SHALL make idex_memread 0 next cycle, so each load-use hazard costs exactly one stall cycle.
REQ-033 lu coincident with a taken branch SHALL be ignored: no stall, and stall_cnt is not incremented.
REQ-034 Normal operation SHALL drive pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0 and freeze=0.
REQ-035 stall_cnt SHALL increment in every non-reset cycle with pc_write=0, both lu stalls and mem_busy cycles.
REQ-036 stall_cnt and flush_cnt SHALL saturate at 2^CNT_W-1, with no wrap.
REQ-037 idex_rd=0 SHALL never cause a stall.

Reset
REQ-038 While reset=1, outputs SHALL be pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, freeze=0.
REQ-039 On a clock edge with reset=1, state SHALL become RUN, and br_pending, flush_left, stall_cnt and flush_cnt SHALL become 0.
REQ-040 reset=1 asserted mid-FLUSH or mid-FREEZE SHALL abort the sequence and discard br_pending.

Verification
REQ-041 Load-use: idex_memread=1, idex_rd=5, id_rs1=5 for 1 cycle -> pc_write=0, ifid_write=0, idex_flush=1 that cycle; stall_cnt=1; next cycle, with idex_memread=0, pc_write=1.
REQ-042 rs2 gating: idex_memread=1, idex_rd=7, id_rs2=7 -> stall when id_uses_rs2=1; no stall when id_uses_rs2=0; no stall for idex_rd=0 with id_rs1=0.
REQ-043 Branch, FLUSH_CYCLES=3: branch_taken pulse of 1 cycle -> ifid_flush=idex_flush=1 for 3 consecutive cycles; flush_cnt=1; pc_write=1 throughout.
REQ-044 Freeze with pending branch: mem_busy=1 for 4 cycles with branch_taken=1 in cycle 2 -> all flushes 0 and freeze=1 for 4 cycles; flush on the cycle mem_busy falls; stall_cnt=4; flush_cnt=1.
REQ-045 Simultaneous events: lu and branch_taken in the same cycle -> flush only; stall_cnt unchanged; flush_cnt+1.
REQ-046 Reset mid-FLUSH (FLUSH_CYCLES=4, reset in flush cycle 2) -> next cycle in RUN, counters 0, no further flush; force stall_cnt to 2^CNT_W-1, then stall -> value holds.
